slave_arbiter: RTL and testbench

Round-robin arbiter that shares one wait-stated bus-slave strobe/ready channel between up to `NREQ` requesters. Each requester holds a strobe until it sees ready, matching the handshake used by the slave's ready generator. The arbiter grants one requester at a time, forwards its strobe to the slave, and routes the slave's ready back to the granted requester only. It sits between the master-side request lines and the single slave port. An optional watchdog terminates transfers the slave never acknowledges.

---
 rtl/slave_arbiter.sv | 151 +++++++++++++++
 tb/tb_slave_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_arbiter.sv
// slave_arbiter: round-robin arbiter sharing one wait-stated slave strobe/ready
// channel between NREQ requesters. Each requester holds REQ until its
// READY_OUT bit is seen. The winner's strobe goes to the slave, and the slave's
// ready comes back to the winner only.
//
// Optional watchdog: define SLAVE_ARB_TIMEOUT_EN to end a transfer in its
// TIMEOUT-th BUSY cycle, signalled by READY_OUT and ERR_OUT together.
// Without the macro, ERR_OUT is tied to 0 and BUSY waits indefinitely.
//
// Ports:
//   CLK        in        clock, all logic on posedge
//   RESET      in        synchronous active-high reset
//   REQ        in  NREQ  per-requester strobe
//   GNT        out NREQ  registered one-hot grant
//   READY_OUT  out NREQ  per-requester ready (combinational pass-through)
//   ERR_OUT    out NREQ  per-requester watchdog error, pulsed with READY_OUT
//   SLV_STROBE out 1     registered strobe to the slave
//   SLV_READY  in  1     ready from the slave
//   BUSY       out 1     high in BUSY and RELEASE
module slave_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] GNT,
    output logic [NREQ-1:0] READY_OUT,
    output logic [NREQ-1:0] ERR_OUT,
    output logic            SLV_STROBE,
    input  logic            SLV_READY,
    output logic            BUSY
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   gidx_q, gidx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            strobe_q, strobe_d;

    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic            fire;
    logic            req_g;

    // First pending requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!pick_valid && REQ[PW'(idx)]) begin
                pick_valid = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    assign req_g = REQ[gidx_q];

`ifdef SLAVE_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counter reads TIMEOUT in the first BUSY cycle, so it reaches 1 in the
    // TIMEOUT-th BUSY cycle.
    assign fire = (state_q == StBusy) && (cnt_q == 16'd1) && !SLV_READY;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle && pick_valid) begin
            cnt_d = 16'(TIMEOUT);
        end else if (state_q == StBusy) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT);
    assign fire           = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        strobe_d = strobe_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gidx_d          = pick_idx;
                    strobe_d        = 1'b1;
                    state_d         = StBusy;
                end
            end
            StBusy: begin
                // Completion, abort and watchdog share one exit path.
                if (SLV_READY || !req_g || fire) begin
                    gnt_d    = '0;
                    strobe_d = 1'b0;
                    ptr_d    = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d  = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            strobe_q <= strobe_d;
        end
    end

    assign GNT        = gnt_q;
    assign SLV_STROBE = strobe_q;
    assign BUSY       = (state_q != StIdle);
    assign READY_OUT  = (state_q == StBusy) ? (gnt_q & {NREQ{SLV_READY | fire}}) : '0;
    assign ERR_OUT    = fire ? gnt_q : '0;

endmodule

// File: tb/tb_slave_arbiter.sv
// Self-checking bench for slave_arbiter (NREQ=4, TIMEOUT=8). Expected grant
// indices go into a queue when requests are driven and are popped when a
// grant is observed. Inputs change 1 time unit after posedge; outputs are
// read 1-2 time units after that.
module tb_slave_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 8;

    logic            CLK;
    logic            RESET;
    logic [NREQ-1:0] REQ;
    logic [NREQ-1:0] GNT;
    logic [NREQ-1:0] READY_OUT;
    logic [NREQ-1:0] ERR_OUT;
    logic            SLV_STROBE;
    logic            SLV_READY;
    logic            BUSY;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    slave_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .GNT        (GNT),
        .READY_OUT  (READY_OUT),
        .ERR_OUT    (ERR_OUT),
        .SLV_STROBE (SLV_STROBE),
        .SLV_READY  (SLV_READY),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET     = 1'b1;
        REQ       = '0;
        SLV_READY = 1'b0;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if (GNT !== 4'b0000) begin
            n_bad++; $display("FAIL reset_gnt: got %b want 0000", GNT);
        end
        n_cmp++;
        if (SLV_STROBE !== 1'b0) begin
            n_bad++; $display("FAIL reset_strobe: got %b want 0", SLV_STROBE);
        end
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY);
        end
        n_cmp++;
        if (READY_OUT !== 4'b0000 || ERR_OUT !== 4'b0000) begin
            n_bad++; $display("FAIL reset_ready_err: got %b/%b want 0000/0000", READY_OUT, ERR_OUT);
        end
    endtask

    task automatic test_single();
        int strobe_cycles = 0;
        int e;
        do_reset();
        REQ = 4'b0001;
        exp_q.push_back(0);
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (GNT !== (4'b0001 << e) || BUSY !== 1'b1) begin
            n_bad++; $display("FAIL single_gnt: got gnt=%b busy=%b want gnt=%b busy=1",
                              GNT, BUSY, 4'b0001 << e);
        end
        for (int c = 1; c <= 6; c++) begin
            if (c == 6) SLV_READY = 1'b1;
            #1;
            if (SLV_STROBE === 1'b1) strobe_cycles++;
            n_cmp++;
            if (READY_OUT !== ((c == 6) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL single_ready_c%0d: got %b", c, READY_OUT);
            end
            step();
        end
        SLV_READY = 1'b0;
        REQ       = 4'b0000;
        n_cmp++;
        if (strobe_cycles != 6) begin
            n_bad++; $display("FAIL single_strobe_len: got %0d want 6", strobe_cycles);
        end
        n_cmp++;
        if (GNT !== 4'b0000 || SLV_STROBE !== 1'b0 || BUSY !== 1'b1) begin
            n_bad++; $display("FAIL single_release: got gnt=%b strobe=%b busy=%b want 0000/0/1",
                              GNT, SLV_STROBE, BUSY);
        end
        step();
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_bad++; $display("FAIL single_idle: got busy=%b want 0", BUSY);
        end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
        REQ = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (GNT !== (4'b0001 << e)) begin
                n_bad++; $display("FAIL rr_gnt_%0d: got %b want %b", k, GNT, 4'b0001 << e);
            end
            SLV_READY = 1'b1;
            #1;
            n_cmp++;
            if (READY_OUT !== (4'b0001 << e)) begin
                n_bad++; $display("FAIL rr_ready_%0d: got %b want %b", k, READY_OUT, 4'b0001 << e);
            end
            step();
            SLV_READY = 1'b0;
            REQ[e]    = 1'b0;
            n_cmp++;
            if (GNT !== 4'b0000 || SLV_STROBE !== 1'b0 || BUSY !== 1'b1) begin
                n_bad++; $display("FAIL rr_release_%0d: got gnt=%b strobe=%b busy=%b",
                                  k, GNT, SLV_STROBE, BUSY);
            end
            step();
            if (k < 4) REQ[e] = 1'b1;
            else       REQ    = 4'b0000;
            n_cmp++;
            if (BUSY !== 1'b0 || SLV_STROBE !== 1'b0) begin
                n_bad++; $display("FAIL rr_idle_%0d: got busy=%b strobe=%b want 0/0",
                                  k, BUSY, SLV_STROBE);
            end
            step();
        end
    endtask

    task automatic test_simultaneous();
        int e;
        do_reset();
        REQ = 4'b0010;
        exp_q.push_back(1);
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (GNT !== (4'b0001 << e)) begin
            n_bad++; $display("FAIL simul_gnt: got %b want %b", GNT, 4'b0001 << e);
        end
        step();
        REQ       = 4'b0000;
        SLV_READY = 1'b1;
        #1;
        n_cmp++;
        if (READY_OUT !== 4'b0010 || ERR_OUT !== 4'b0000) begin
            n_bad++; $display("FAIL simul_ready: got ready=%b err=%b want 0010/0000",
                              READY_OUT, ERR_OUT);
        end
        step();
        SLV_READY = 1'b0;
        REQ       = 4'b1111;
        exp_q.push_back(2);
        step();
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (GNT !== (4'b0001 << e)) begin
            n_bad++; $display("FAIL simul_ptr: got %b want %b", GNT, 4'b0001 << e);
        end
        REQ = 4'b0000;
        step();
        step();
        step();
    endtask

    task automatic test_abort();
        int e;
        do_reset();
        REQ = 4'b0100;
        exp_q.push_back(2);
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (GNT !== (4'b0001 << e)) begin
            n_bad++; $display("FAIL abort_gnt: got %b want %b", GNT, 4'b0001 << e);
        end
        REQ = 4'b1100;
        step();
        step();
        step();
        REQ = 4'b1000;
        exp_q.push_back(3);
        #1;
        n_cmp++;
        if (READY_OUT !== 4'b0000) begin
            n_bad++; $display("FAIL abort_no_ready: got %b want 0000", READY_OUT);
        end
        step();
        n_cmp++;
        if (GNT !== 4'b0000 || SLV_STROBE !== 1'b0 || READY_OUT !== 4'b0000) begin
            n_bad++; $display("FAIL abort_exit: got gnt=%b strobe=%b ready=%b",
                              GNT, SLV_STROBE, READY_OUT);
        end
        step();
        step();
        e = exp_q.pop_front();
        n_cmp++;
        if (GNT !== (4'b0001 << e)) begin
            n_bad++; $display("FAIL abort_next: got %b want %b", GNT, 4'b0001 << e);
        end
        REQ = 4'b0000;
        step();
        step();
        step();
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int run = 0; run < 2; run++) begin
            REQ = 4'b0001;
            step();
            n_cmp++;
            if (GNT !== 4'b0001) begin
                n_bad++; $display("FAIL wd_gnt_r%0d: got %b want 0001", run, GNT);
            end
`ifdef SLAVE_ARB_TIMEOUT_EN
            for (int c = 1; c < int'(TIMEOUT); c++) begin
                n_cmp++;
                if (READY_OUT !== 4'b0000 || ERR_OUT !== 4'b0000) begin
                    n_bad++; $display("FAIL wd_early_r%0d_c%0d: got ready=%b err=%b",
                                      run, c, READY_OUT, ERR_OUT);
                end
                step();
            end
            SLV_READY = (run == 1);
            #1;
            n_cmp++;
            if (READY_OUT !== 4'b0001 || ERR_OUT !== ((run == 0) ? 4'b0001 : 4'b0000)) begin
                n_bad++; $display("FAIL wd_fire_r%0d: got ready=%b err=%b want 0001/%b",
                                  run, READY_OUT, ERR_OUT, (run == 0) ? 4'b0001 : 4'b0000);
            end
            step();
            SLV_READY = 1'b0;
            REQ       = 4'b0000;
            n_cmp++;
            if (GNT !== 4'b0000 || SLV_STROBE !== 1'b0 || BUSY !== 1'b1) begin
                n_bad++; $display("FAIL wd_release_r%0d: got gnt=%b strobe=%b busy=%b",
                                  run, GNT, SLV_STROBE, BUSY);
            end
`else
            for (int c = 1; c <= 20; c++) begin
                n_cmp++;
                if (READY_OUT !== 4'b0000 || ERR_OUT !== 4'b0000 || GNT !== 4'b0001) begin
                    n_bad++; $display("FAIL wd_off_r%0d_c%0d: got ready=%b err=%b gnt=%b",
                                      run, c, READY_OUT, ERR_OUT, GNT);
                end
                step();
            end
            REQ = 4'b0000;
            step();
`endif
            step();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        REQ = 4'b0100;
        step();
        REQ = 4'b1111;
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_cmp++;
        if (GNT !== 4'b0000 || SLV_STROBE !== 1'b0 || BUSY !== 1'b0 ||
            READY_OUT !== 4'b0000 || ERR_OUT !== 4'b0000) begin
            n_bad++; $display("FAIL midreset_outputs: got gnt=%b strobe=%b busy=%b ready=%b err=%b",
                              GNT, SLV_STROBE, BUSY, READY_OUT, ERR_OUT);
        end
        exp_q.push_back(0);
        step();
        n_cmp++;
        if (GNT !== (4'b0001 << exp_q.pop_front())) begin
            n_bad++; $display("FAIL midreset_ptr: got %b want 0001", GNT);
        end
        REQ = 4'b0000;
        step();
        step();
    endtask

    initial begin
        RESET     = 1'b1;
        REQ       = '0;
        SLV_READY = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_simultaneous();
        test_abort();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
